// File: rtl/serial_word_deserializer.sv
// MSB-first framed serial-to-parallel receiver with a one-entry valid/ready output buffer; word_valid rises 1 cycle after the final bit.
// A completed word that finds the buffer full is dropped and sets sticky overrun; `define PARITY_CHECK_EN adds a trailing even-parity bit.
module serial_word_deserializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             word_perr
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PARITY_CHECK_EN
    ,
    PARITY
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shift_in;
  logic             done;
  logic             buf_free;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
  logic             perr_new;
`endif

  assign shift_in = {shift_q[WIDTH-2:0], sin_data};
  assign buf_free = !vld_q || word_ready;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_new = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sin_valid && sin_start) begin
          shift_d = shift_in;
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          shift_d = shift_in;
          if (sin_start) begin
            cnt_d = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (sin_valid) begin
          if (sin_start) begin
            shift_d = shift_in;
            cnt_d   = CNT_ONE;
            state_d = SHIFT;
          end else begin
            // parity bit is checked but never enters the data word
            done     = 1'b1;
            perr_new = (^shift_q) ^ sin_data;
            state_d  = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // shift_d equals the finished word in every state that can raise done
  always_comb begin
    word_d = word_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
`ifdef PARITY_CHECK_EN
    perr_d = perr_q;
`endif
    if (done) begin
      if (buf_free) begin
        word_d = shift_d;
        vld_d  = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_d = perr_new;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && word_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign word_data  = word_q;
  assign word_valid = vld_q;
  assign overrun    = ovr_q;
`ifdef PARITY_CHECK_EN
  assign word_perr  = perr_q;
`else
  assign word_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Randomized bench for serial_word_deserializer against a frame-level model built from bit queues.
// Honours PARITY_CHECK_EN when it is defined for the build.
module tb_serial_word_deserializer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_data = 1'b0;
  logic             sin_start = 1'b0;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready = 1'b0;
  logic             overrun;
  logic             word_perr;

  int n_chk  = 0;
  int n_fail = 0;

  // frame-level model state
  bit             m_in = 1'b0;
  bit             bq[$];
  bit             m_vld = 1'b0;
  logic [WIDTH-1:0] m_dat = '0;
  bit             m_ovr = 1'b0;
  bit             m_perr = 1'b0;

  serial_word_deserializer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .sin_valid  (sin_valid),
    .sin_data   (sin_data),
    .sin_start  (sin_start),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .word_perr  (word_perr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit rdy_pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(1));
  endfunction

  // advance the model by one clock given this cycle's inputs
  task automatic model_step(input bit v, input bit d, input bit s, input bit r, input bit c);
    bit             comp;
    bit             pe;
    logic [WIDTH-1:0] w;
    comp = 1'b0;
    pe   = 1'b0;
    w    = '0;
    if (c) begin
      m_in = 1'b0;
      bq.delete();
      m_vld = 1'b0;
      m_dat = '0;
      m_ovr = 1'b0;
      m_perr = 1'b0;
      return;
    end
    if (v) begin
      if (s) begin
        bq.delete();
        bq.push_back(d);
        m_in = 1'b1;
      end else if (m_in) begin
        if (bq.size() == WIDTH) begin
          comp = 1'b1;
          pe   = d;
          m_in = 1'b0;
        end else begin
          bq.push_back(d);
`ifndef PARITY_CHECK_EN
          if (bq.size() == WIDTH) begin
            comp = 1'b1;
            m_in = 1'b0;
          end
`endif
        end
      end
    end
    if (comp) begin
      foreach (bq[i]) begin
        w  = {w[WIDTH-2:0], bq[i]};
        pe = pe ^ bq[i];
      end
      if (!m_vld || r) begin
        m_vld = 1'b1;
        m_dat = w;
`ifdef PARITY_CHECK_EN
        m_perr = pe;
`else
        m_perr = 1'b0;
`endif
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_vld && r) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_val("word_valid", 32'(word_valid), 32'(m_vld));
    check_val("word_data", 32'(word_data), 32'(m_dat));
    check_val("overrun", 32'(overrun), 32'(m_ovr));
    check_val("word_perr", 32'(word_perr), 32'(m_perr));
  endtask

  task automatic cyc(input bit v, input bit d, input bit s, input bit r, input bit c);
    sin_valid  = v;
    sin_data   = d;
    sin_start  = s;
    word_ready = r;
    clear      = c;
    model_step(v, d, s, r, c || rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // nbits < WIDTH sends an aborted partial frame; last_rdy < 0 keeps rmode on the final cycle
  task automatic send_frame(input logic [WIDTH-1:0] w, input int nbits, input int rmode,
                            input int last_rdy, input int gap_pct, input bit par_bad);
    int total;
    total = nbits;
`ifdef PARITY_CHECK_EN
    if (nbits == WIDTH) total = WIDTH + 1;
`endif
    for (int i = 0; i < total; i++) begin
      bit b;
      bit r;
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++)
        cyc(1'b0, 1'($urandom), 1'($urandom), rdy_pick(rmode), 1'b0);
      if (i < WIDTH) b = w[WIDTH-1-i];
      else           b = (^w) ^ par_bad;
      if (i == total - 1 && last_rdy >= 0) r = last_rdy[0];
      else                                 r = rdy_pick(rmode);
      cyc(1'b1, b, i == 0, r, 1'b0);
    end
  endtask

  initial begin
    // reset then idle noise without a start bit
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom), 1'b0);
    check_val("idle_valid", 32'(word_valid), 32'd0);
    check_val("idle_data", 32'(word_data), 32'h0000);
    check_val("idle_ovr", 32'(overrun), 32'd0);

    // single back-to-back frame, valid one cycle after the final bit
    send_frame(16'hA5C3, WIDTH, 1, -1, 0, 1'b0);
    check_val("single_valid", 32'(word_valid), 32'd1);
    check_val("single_data", 32'(word_data), 32'hA5C3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("single_drop", 32'(word_valid), 32'd0);

    // partial gapped frame, then restart with a complete one
    send_frame(16'h1234, 7, 1, -1, 40, 1'b0);
    check_val("restart_novalid", 32'(word_valid), 32'd0);
    send_frame(16'hBEEF, WIDTH, 0, -1, 40, 1'b0);
    check_val("restart_data", 32'(word_data), 32'hBEEF);
    check_val("restart_valid", 32'(word_valid), 32'd1);
    check_val("restart_ovr", 32'(overrun), 32'd0);

    // overrun when the buffer is still full
    do_reset();
    send_frame(16'h1111, WIDTH, 0, -1, 0, 1'b0);
    send_frame(16'h2222, WIDTH, 0, -1, 0, 1'b0);
    check_val("ovr_data", 32'(word_data), 32'h1111);
    check_val("ovr_flag", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("ovr_sticky", 32'(overrun), 32'd1);

    // accept and complete in the same cycle
    do_reset();
    send_frame(16'h1111, WIDTH, 0, -1, 0, 1'b0);
    send_frame(16'h2222, WIDTH, 0, 1, 0, 1'b0);
    check_val("simul_data", 32'(word_data), 32'h2222);
    check_val("simul_ovr", 32'(overrun), 32'd0);
    check_val("simul_valid", 32'(word_valid), 32'd1);

    // clear after nine bits discards the partial frame
    send_frame(16'hFFFF, 9, 1, -1, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("clr_valid", 32'(word_valid), 32'd0);
    check_val("clr_data", 32'(word_data), 32'h0000);
    send_frame(16'h00FF, WIDTH, 1, -1, 0, 1'b0);
    check_val("clr_next_data", 32'(word_data), 32'h00FF);
    check_val("clr_next_valid", 32'(word_valid), 32'd1);

`ifdef PARITY_CHECK_EN
    send_frame(16'h0001, WIDTH, 1, -1, 0, 1'b0);
    check_val("par_good", 32'(word_perr), 32'd0);
    send_frame(16'h0001, WIDTH, 1, -1, 0, 1'b1);
    check_val("par_bad", 32'(word_perr), 32'd1);
`endif

    // randomized traffic: aborts, noise, clears, gaps and consumer stalls
    for (int f = 0; f < 300; f++) begin
      int kind;
      kind = int'($urandom_range(99));
      if (kind < 10) begin
        send_frame(WIDTH'($urandom), int'($urandom_range(WIDTH - 1, 1)), 2, -1, 30, 1'b0);
      end else if (kind < 15) begin
        cyc(1'b0, 1'b0, 1'b0, rdy_pick(2), 1'b1);
      end else if (kind < 25) begin
        for (int k = 0; k < int'($urandom_range(3, 1)); k++)
          cyc(1'b1, 1'($urandom), 1'b0, rdy_pick(2), 1'b0);
      end
      send_frame(WIDTH'($urandom), WIDTH, 2, -1, int'($urandom_range(50)),
                 1'($urandom_range(1)));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
